// File: rtl/cp0_timer_interrupt_unit.sv
// CP0 Count/Compare timer, Status/Cause interrupt state and registered interrupt request to fetch.
// Build option CP0_HW_IRQ_LATCH_EN makes hardware interrupt lines edge-latched instead of level.
module cp0_timer_interrupt_unit #(
    parameter int COUNT_WIDTH = 32,
    parameter int NUM_COMPARE = 1,
    parameter int PRESCALE    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             hardware_interrupt,
    input  logic                   reg_write_enabled,
    input  logic [4:0]             reg_address,
    input  logic [2:0]             reg_select,
    input  logic [31:0]            reg_write_data,
    output logic [31:0]            reg_read_data,
    input  logic                   exception_valid,
    input  logic                   eret_flush,
    output logic                   interrupt_request,
    output logic [NUM_COMPARE-1:0] timer_pending,
    output logic                   status_exception_level
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic [PS_W-1:0]        prescaler;
    logic [COUNT_WIDTH-1:0] compare [NUM_COMPARE];
    logic [5:0]             sync_q [SYNC_STAGES];
    logic [5:0]             hw_sync;
    logic [5:0]             hw_src;
    logic [7:0]             im;
    logic                   ie;
    logic                   exl;
    logic [1:0]             ip_sw;
    logic [7:0]             ip;
    logic                   ti;
    logic                   tick;
    logic                   count_wr;
    logic                   status_wr;
    logic                   cause_wr;
    logic [NUM_COMPARE-1:0] compare_wr;
    logic [NUM_COMPARE-1:0] match;

    always_comb begin
        count_wr   = reg_write_enabled && (reg_address == 5'd9)  && (reg_select == 3'd0);
        status_wr  = reg_write_enabled && (reg_address == 5'd12) && (reg_select == 3'd0);
        cause_wr   = reg_write_enabled && (reg_address == 5'd13) && (reg_select == 3'd0);
        compare_wr = '0;
        for (int k = 0; k < NUM_COMPARE; k++) begin
            compare_wr[k] = reg_write_enabled && (reg_address == 5'd11) && (reg_select == 3'(k));
        end
    end

    // A Count write restarts the prescaler and suppresses the tick in that cycle.
    assign tick      = !count_wr && (prescaler == PS_LAST);
    assign count_inc = count + COUNT_WIDTH'(1);

    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_COMPARE; k++) begin
            match[k] = tick && (count_inc == compare[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            prescaler <= '0;
        end else if (count_wr) begin
            count     <= reg_write_data[COUNT_WIDTH-1:0];
            prescaler <= '0;
        end else if (tick) begin
            count     <= count_inc;
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PS_W'(1);
        end
    end

    // Compare write clears its pending bit and wins over a match in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_COMPARE; k++) begin
                compare[k] <= '1;
            end
            timer_pending <= '0;
        end else begin
            for (int k = 0; k < NUM_COMPARE; k++) begin
                if (compare_wr[k]) begin
                    compare[k]       <= reg_write_data[COUNT_WIDTH-1:0];
                    timer_pending[k] <= 1'b0;
                end else if (match[k]) begin
                    timer_pending[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= hardware_interrupt;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign hw_sync = sync_q[SYNC_STAGES-1];

`ifdef CP0_HW_IRQ_LATCH_EN
    logic [5:0] hw_sync_d;
    logic [5:0] hw_latch;
    logic [5:0] hw_rise;
    logic [5:0] hw_keep;

    assign hw_rise = hw_sync & ~hw_sync_d;
    assign hw_keep = cause_wr ? reg_write_data[15:10] : 6'h3f;

    always_ff @(posedge clock) begin
        if (reset) begin
            hw_sync_d <= '0;
            hw_latch  <= '0;
        end else begin
            hw_sync_d <= hw_sync;
            hw_latch  <= (hw_latch & hw_keep) | hw_rise;
        end
    end

    // The rising edge is visible in IP the same cycle it is captured.
    assign hw_src = hw_latch | hw_rise;
`else
    assign hw_src = hw_sync;
`endif

    assign ti = |timer_pending;
    assign ip = {hw_src[5] | ti, hw_src[4:0], ip_sw};

    always_ff @(posedge clock) begin
        if (reset) begin
            im                <= '0;
            ie                <= 1'b0;
            exl               <= 1'b0;
            ip_sw             <= '0;
            interrupt_request <= 1'b0;
        end else begin
            if (status_wr) begin
                im <= reg_write_data[15:8];
                ie <= reg_write_data[0];
            end
            if (exception_valid) begin
                exl <= 1'b1;
            end else if (eret_flush) begin
                exl <= 1'b0;
            end else if (status_wr) begin
                exl <= reg_write_data[1];
            end
            if (cause_wr) begin
                ip_sw <= reg_write_data[9:8];
            end
            interrupt_request <= (|(ip & im)) & ie & ~exl;
        end
    end

    assign status_exception_level = exl;

    always_comb begin
        reg_read_data = '0;
        case (reg_address)
            5'd9: begin
                if (reg_select == 3'd0) reg_read_data = 32'(count);
            end
            5'd11: begin
                for (int k = 0; k < NUM_COMPARE; k++) begin
                    if (reg_select == 3'(k)) reg_read_data = 32'(compare[k]);
                end
            end
            5'd12: begin
                if (reg_select == 3'd0) reg_read_data = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
            end
            5'd13: begin
                if (reg_select == 3'd0)      reg_read_data = {1'b0, ti, 14'd0, ip, 8'd0};
                else if (reg_select == 3'd1) reg_read_data = 32'(timer_pending);
            end
            default: ;
        endcase
    end

endmodule
